uc_stall_seq: RTL and testbench

Parametrised multi-channel stall sequencer for the microcontroller control unit; next generation of the fixed two-cycle conditional-jump hold counter. Each of NCH requesters (conditional jump, memory wait, multi-cycle ALU, ...) triggers a stall whose length comes from its own len input. Overlapping requests are queued and served in fixed priority. The block drives a single stall line to the fetch/decode stages, with a freeze input and an abort/flush input.

---
 rtl/uc_stall_pkg.sv | 22 ++
 rtl/uc_prio_pick.sv | 23 ++
 rtl/uc_stall_seq.sv | 119 +++++++++++
 tb/tb_uc_stall_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_stall_pkg.sv
// Shared constants for the stall sequencer: default sizes, FSM state
// encoding and the channel-index width helper.
package uc_stall_pkg;

   localparam int DEF_CNT_W = 2;
   localparam int DEF_NCH   = 2;

   // Two-state FSM: IDLE while the counter is zero, RUN while a stall is served
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   // Index width for n items, never narrower than one bit so NCH=1 still works
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/uc_prio_pick.sv
// Lowest-index-first picker: reports whether any request is set and the
// index of the lowest set bit.
module uc_prio_pick
   import uc_stall_pkg::*;
#(
   parameter int N = 2,
   parameter int W = clog2_min1(N)
) (
   input  logic [N-1:0] req,
   output logic         any,
   output logic [W-1:0] index
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      any   = |req;
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) index = W'(i);
      end
   end

endmodule

// File: rtl/uc_stall_seq.sv
// Multi-channel stall sequencer. Each channel requests a stall of its own
// length; overlapping requests queue in a pending vector (with the length
// latched per channel) and are served lowest-index first, back to back.
module uc_stall_seq
   import uc_stall_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int NCH   = DEF_NCH,
   parameter int CH_W  = clog2_min1(NCH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NCH-1:0]     trig,
   input  logic [NCH*CNT_W-1:0] len,
   input  logic               hold,
   input  logic               abort,
   output logic               stall,
   output logic [CH_W-1:0]    active_ch,
   output logic [NCH-1:0]     pending,
   output logic               done,
   output logic [CH_W-1:0]    done_ch
);

   logic                 state;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     len_q [NCH];

   logic [NCH-1:0]       valid_trig;
   logic [NCH-1:0]       cand;
   logic                 cand_any;
   logic [CH_W-1:0]      cand_idx;
   logic [CNT_W-1:0]     load_len;
   logic [NCH-1:0]       sel_mask;
   logic                 finish;
   logic                 load_evt;
   logic                 do_load;

   // Zero-length requests are ignored entirely; everything else is a candidate
   always_comb begin
      valid_trig = '0;
      for (int i = 0; i < NCH; i++) begin
         valid_trig[i] = trig[i] && (len[i*CNT_W +: CNT_W] != '0);
      end
      cand = pending | valid_trig;
   end

   uc_prio_pick #(
      .N (NCH),
      .W (CH_W)
   ) u_pick (
      .req   (cand),
      .any   (cand_any),
      .index (cand_idx)
   );

   // Winner's length: a fresh trig this edge overrides the latched value
   always_comb begin
      load_len = '0;
      sel_mask = '0;
      for (int i = 0; i < NCH; i++) begin
         if (CH_W'(i) == cand_idx) begin
            load_len = valid_trig[i] ? len[i*CNT_W +: CNT_W] : len_q[i];
            sel_mask[i] = do_load;
         end
      end
   end

   // A new stall loads when idle or on the final decrement, so queued stalls chain without a gap
   always_comb begin
      finish   = (state == ST_RUN) && !hold && (count == CNT_W'(1));
      load_evt = (state == ST_IDLE) || finish;
      do_load  = load_evt && cand_any;
   end

   // Per-channel length latch; a repeated trig simply overwrites the old length
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) len_q[i] <= '0;
      end else if (!abort) begin
         for (int i = 0; i < NCH; i++) begin
            if (valid_trig[i]) len_q[i] <= len[i*CNT_W +: CNT_W];
         end
      end
   end

   // Main sequencer: reset beats abort, which beats load/decrement and queuing
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         count     <= '0;
         pending   <= '0;
         active_ch <= '0;
         done      <= 1'b0;
         done_ch   <= '0;
      end else if (abort) begin
         state   <= ST_IDLE;
         count   <= '0;
         pending <= '0;
         done    <= 1'b0;
      end else begin
         done    <= finish;
         pending <= cand & ~sel_mask;
         if (finish) done_ch <= active_ch;
         if (do_load) begin
            state     <= ST_RUN;
            count     <= load_len;
            active_ch <= cand_idx;
         end else if (finish) begin
            state <= ST_IDLE;
            count <= '0;
         end else if ((state == ST_RUN) && !hold) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   assign stall = (state == ST_RUN);

endmodule

// File: tb/tb_uc_stall_seq.sv
// Scoreboard bench for uc_stall_seq (NCH=3, CNT_W=3). The driver steps a
// remaining-cycles reference model and queues the expected outputs; a
// separate monitor compares them one cycle at a time after each edge.
module tb_uc_stall_seq;

   localparam int NCH   = 3;
   localparam int CNT_W = 3;
   localparam int CH_W  = 2;

   typedef struct {
      logic            stall;
      logic [NCH-1:0]  pending;
      logic [CH_W-1:0] act;
      logic            done;
      logic [CH_W-1:0] done_ch;
      bit              chk_act;
      bit              chk_dch;
   } exp_t;

   logic                 clk;
   logic                 reset;
   logic [NCH-1:0]       trig;
   logic [NCH*CNT_W-1:0] len;
   logic                 hold;
   logic                 abort;
   logic                 stall;
   logic [CH_W-1:0]      active_ch;
   logic [NCH-1:0]       pending;
   logic                 done;
   logic [CH_W-1:0]      done_ch;

   int checks;
   int errors;

   exp_t exp_q [$];
   int   done_q [$];

   int m_rem;
   int m_act;
   int m_dch;
   bit m_done;
   bit m_pend [NCH];
   int m_len  [NCH];

   uc_stall_seq #(
      .CNT_W (CNT_W),
      .NCH   (NCH),
      .CH_W  (CH_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .trig      (trig),
      .len       (len),
      .hold      (hold),
      .abort     (abort),
      .stall     (stall),
      .active_ch (active_ch),
      .pending   (pending),
      .done      (done),
      .done_ch   (done_ch)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [NCH*CNT_W-1:0] packLen(input int l0, input int l1, input int l2);
      logic [NCH*CNT_W-1:0] v;
      v = '0;
      v[0*CNT_W +: CNT_W] = CNT_W'(l0);
      v[1*CNT_W +: CNT_W] = CNT_W'(l1);
      v[2*CNT_W +: CNT_W] = CNT_W'(l2);
      return v;
   endfunction

   // Reference model: a stall is "remaining cycles"; requests sit in a set, lowest index served next
   task automatic modelStep(input logic [NCH-1:0] t, input logic [NCH*CNT_W-1:0] l,
                            input logic h, input logic a, input logic r, output exp_t e);
      bit need_load;
      bit found;
      int lv;
      e.chk_act = 1'b0;
      e.chk_dch = 1'b0;
      if (r) begin
         m_rem = 0; m_act = 0; m_dch = 0; m_done = 0;
         for (int c = 0; c < NCH; c++) m_pend[c] = 0;
         e.chk_act = 1'b1;
         e.chk_dch = 1'b1;
      end else if (a) begin
         m_rem = 0; m_done = 0;
         for (int c = 0; c < NCH; c++) m_pend[c] = 0;
      end else begin
         m_done = 0;
         for (int c = 0; c < NCH; c++) begin
            lv = int'(l[c*CNT_W +: CNT_W]);
            if (t[c] && lv != 0) begin
               m_pend[c] = 1;
               m_len[c]  = lv;
            end
         end
         need_load = (m_rem == 0);
         if (m_rem != 0 && !h) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_done = 1;
               m_dch  = m_act;
               done_q.push_back(m_act);
               need_load = 1;
            end
         end
         if (need_load) begin
            found = 0;
            for (int c = 0; c < NCH; c++) begin
               if (!found && m_pend[c]) begin
                  found     = 1;
                  m_act     = c;
                  m_rem     = m_len[c];
                  m_pend[c] = 0;
               end
            end
         end
      end
      e.stall = (m_rem != 0);
      for (int c = 0; c < NCH; c++) e.pending[c] = m_pend[c];
      e.act     = CH_W'(m_act);
      e.done    = m_done;
      e.done_ch = CH_W'(m_dch);
      if (e.stall) e.chk_act = 1'b1;
      if (e.done)  e.chk_dch = 1'b1;
   endtask

   // Drive one cycle of inputs away from the edge and queue the expected response
   task automatic applyStimulus(input logic [NCH-1:0] t, input logic [NCH*CNT_W-1:0] l,
                                input logic h, input logic a, input logic r);
      exp_t e;
      @(negedge clk);
      trig  = t;
      len   = l;
      hold  = h;
      abort = a;
      reset = r;
      modelStep(t, l, h, a, r, e);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if (stall !== e.stall) begin
         errors++;
         $display("[TB] FAIL stall at %0t: got %b expected %b", $time, stall, e.stall);
      end
      checks++;
      if (pending !== e.pending) begin
         errors++;
         $display("[TB] FAIL pending at %0t: got %b expected %b", $time, pending, e.pending);
      end
      checks++;
      if (done !== e.done) begin
         errors++;
         $display("[TB] FAIL done at %0t: got %b expected %b", $time, done, e.done);
      end
      if (e.chk_act) begin
         checks++;
         if (active_ch !== e.act) begin
            errors++;
            $display("[TB] FAIL active_ch at %0t: got %0d expected %0d", $time, active_ch, e.act);
         end
      end
      if (e.chk_dch) begin
         checks++;
         if (done_ch !== e.done_ch) begin
            errors++;
            $display("[TB] FAIL done_ch at %0t: got %0d expected %0d", $time, done_ch, e.done_ch);
         end
      end
   endtask

   // Monitor: one queued expectation per edge, plus a completion scoreboard keyed on done
   initial begin
      exp_t e;
      int   want;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
            if (done === 1'b1) begin
               checks++;
               if (done_q.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL done_seq at %0t: got done for ch %0d expected no completion", $time, done_ch);
               end else begin
                  want = done_q.pop_front();
                  if (int'(done_ch) != want) begin
                     errors++;
                     $display("[TB] FAIL done_seq at %0t: got ch %0d expected ch %0d", $time, done_ch, want);
                  end
               end
            end
         end
      end
   end

   // Directed scenarios first, then randomized traffic, then the summary
   initial begin
      int rt, rl, rh, ra, rr;
      trig = '0; len = '0; hold = 1'b0; abort = 1'b0; reset = 1'b1;
      m_rem = 0; m_act = 0; m_dch = 0; m_done = 0;
      for (int c = 0; c < NCH; c++) begin
         m_pend[c] = 0;
         m_len[c]  = 0;
      end
      checks = 0;
      errors = 0;

      applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
      applyStimulus('0, '0, 1'b1, 1'b0, 1'b1);
      idle(2);

      // Single stall of 2 cycles
      applyStimulus(3'b001, packLen(2, 0, 0), 1'b0, 1'b0, 1'b0);
      idle(4);

      // Two simultaneous requests served back to back
      applyStimulus(3'b011, packLen(2, 3, 0), 1'b0, 1'b0, 1'b0);
      idle(7);

      // Hold freezes a running count for two cycles
      applyStimulus(3'b001, packLen(3, 0, 0), 1'b0, 1'b0, 1'b0);
      idle(1);
      applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
      applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
      idle(5);

      // Hold while idle does not block a load
      applyStimulus(3'b100, packLen(0, 0, 2), 1'b1, 1'b0, 1'b0);
      idle(4);

      // Abort with a queued request and a simultaneous trig
      applyStimulus(3'b011, packLen(4, 2, 0), 1'b0, 1'b0, 1'b0);
      idle(1);
      applyStimulus(3'b001, packLen(3, 0, 0), 1'b0, 1'b1, 1'b0);
      idle(3);

      // Zero-length trig is ignored, then reset in the middle of a stall
      applyStimulus(3'b001, packLen(0, 0, 0), 1'b0, 1'b0, 1'b0);
      idle(3);
      applyStimulus(3'b001, packLen(5, 0, 0), 1'b0, 1'b0, 1'b0);
      idle(2);
      applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
      idle(2);

      // Coalescing: ch2 trig twice during a 7-cycle ch0 stall, last length wins
      applyStimulus(3'b001, packLen(7, 0, 0), 1'b0, 1'b0, 1'b0);
      idle(1);
      applyStimulus(3'b100, packLen(0, 0, 4), 1'b0, 1'b0, 1'b0);
      idle(2);
      applyStimulus(3'b100, packLen(0, 0, 1), 1'b0, 1'b0, 1'b0);
      idle(8);

      // Re-trigger of the active channel and trig on the final edge
      applyStimulus(3'b010, packLen(0, 2, 0), 1'b0, 1'b0, 1'b0);
      applyStimulus(3'b010, packLen(0, 3, 0), 1'b0, 1'b0, 1'b0);
      applyStimulus(3'b001, packLen(1, 0, 0), 1'b0, 1'b0, 1'b0);
      idle(8);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rt = $urandom_range(0, 3);
         rl = $urandom;
         rh = $urandom_range(0, 4);
         ra = $urandom_range(0, 49);
         rr = $urandom_range(0, 199);
         applyStimulus((rt == 0) ? NCH'($urandom) : '0, (NCH*CNT_W)'(rl),
                       rh == 0, ra == 0, rr == 0);
      end
      idle(12);

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0 || done_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d cycle and %0d completion entries left expected 0 and 0",
                  exp_q.size(), done_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
